gps_ack_peak: RTL and testbench
===============================

Name: gps_ack_peak

Overview:
- Downstream stage of the GPS acquisition correlator.
- Consumes one correlation result per code phase (code_phase, integrator value, corr_complete strobe).
- Over a full sweep of N_PHASES results it tracks the peak, its phase and the running sum, then issues a found/not-found decision for the swept satellite.
- Output feeds the acquisition controller / tracking-channel handover.

Parameters:
- N_PHASES, 1023, correlation results per sweep (one per C/A code phase)
- PHASE_W, 10, code_phase width
- INT_W, 12, integrator width (unsigned magnitude)
- THRESH_Q4, 40, detection ratio peak/mean in Q4.4 unsigned, 8 bits (40 = 2.5)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sweep_start  in  1  one-cycle pulse; begins a new sweep, samples sat_in
- sat_in  in  5  satellite number under test
- corr_complete  in  1  correlator result strobe; level, may stay high several cycles
- code_phase  in  PHASE_W  phase of the current result; valid while corr_complete is high
- integrator  in  INT_W  correlation magnitude for code_phase
- busy  out  1  sweep in progress
- result_valid  out  1  one-cycle pulse when decision outputs update
- acq_found  out  1  peak exceeded threshold
- acq_sat  out  5  satellite of the last decision
- acq_phase  out  PHASE_W  code phase of the peak
- acq_peak  out  INT_W  peak integrator value
- acq_mean  out  INT_W  sum >> 10 (mean approximation)
- phase_err  out  1  sticky within a sweep: a result with code_phase >= N_PHASES was seen

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; internal peak, sum, count, edge-detect register cleared.
- Edge detect: corr_complete is registered; a result is accepted on the cycle corr_complete is high and its registered value is low. code_phase and integrator are sampled on that cycle. One result per rising edge, regardless of high duration.
- States: IDLE, ACCUM, DECIDE.
- IDLE:
  - busy = 0.
  - sweep_start: go to ACCUM next cycle; latch sat_in; clear peak = 0, peak_phase = 0, sum = 0, count = 0, phase_err = 0.
  - Results arriving in IDLE are ignored.
- ACCUM:
  - busy = 1.
  - Per accepted result:
    - if code_phase >= N_PHASES: set phase_err, do not update peak, sum or count.
    - else: sum += integrator (22-bit accumulator, no overflow possible for N_PHASES <= 1024); count += 1.
    - if integrator > peak (strictly greater): peak = integrator, peak_phase = code_phase. On ties the earliest phase is kept.
  - When the result making count == N_PHASES is accepted: go to DECIDE next cycle.
- DECIDE (one cycle):
  - mean = sum[21:10].
  - found = (peak * 16) >= (mean * THRESH_Q4). Unsigned; 16-bit left operand vs 20-bit right operand, compared at 20 bits.
  - Register acq_found, acq_sat, acq_phase, acq_peak, acq_mean. Pulse result_valid the same cycle they update, then return to IDLE.
  - Latency: result_valid is high exactly 2 cycles after the accepting edge of the last result.
  - Outputs hold until the next decision or reset.
- Special case: sum = 0 and peak = 0 gives found = 1 (0 >= 0). This is intended: the controller qualifies decisions with acq_peak != 0.
- sweep_start while in ACCUM: abort the current sweep and restart (clear, latch new sat_in, stay in ACCUM). No result_valid for the aborted sweep.
- sweep_start in the DECIDE cycle: the decision completes normally (result_valid pulses), and the new sweep starts in ACCUM the next cycle.
- sweep_start coincident with an accepted result in ACCUM: restart wins; that result is discarded.
- Reset mid-sweep: immediate return to IDLE; outputs cleared; no result_valid.

Test Plan:
- Flat sweep, sat_in = 4: 1023 results all with integrator = 100 -> result_valid once; acq_sat = 4, acq_phase = 0, acq_peak = 100, acq_mean = 99, found = 0 (1600 < 3960).
- Peak sweep: all 100 except phase 512 = 600 -> acq_phase = 512, acq_peak = 600, acq_mean = 100, found = 1 (9600 >= 4000); result_valid exactly 2 cycles after the last corr_complete rising edge.
- Stretched strobe: corr_complete held 3 cycles per result -> each result counted once; decision after exactly 1023 edges.
- Out-of-range phase: one result with code_phase = 1023 inserted -> phase_err = 1, count unaffected; decision still requires 1023 valid results.
- Tie and abort: equal peaks 300 at phases 10 and 700 -> acq_phase = 10. Then sweep_start after 200 results with sat_in = 7 -> no result_valid; the next full sweep reports acq_sat = 7.
- Async reset asserted mid-ACCUM -> busy and all outputs go to 0 without waiting for a clock edge; no result_valid pulse.

Source files
------------

// File: rtl/gps_ack_peak_if.sv
// gps_ack_peak_if: sweep control, correlator results and decision outputs of the acquisition peak detector
interface gps_ack_peak_if #(
    parameter int PHASE_W = 10,
    parameter int INT_W   = 12
);
    logic               sweep_start;
    logic [4:0]         sat_in;
    logic               corr_complete;
    logic [PHASE_W-1:0] code_phase;
    logic [INT_W-1:0]   integrator;
    logic               busy;
    logic               result_valid;
    logic               acq_found;
    logic [4:0]         acq_sat;
    logic [PHASE_W-1:0] acq_phase;
    logic [INT_W-1:0]   acq_peak;
    logic [INT_W-1:0]   acq_mean;
    logic               phase_err;

    modport master (
        output sweep_start, sat_in, corr_complete, code_phase, integrator,
        input  busy, result_valid, acq_found, acq_sat, acq_phase, acq_peak, acq_mean, phase_err
    );

    modport slave (
        input  sweep_start, sat_in, corr_complete, code_phase, integrator,
        output busy, result_valid, acq_found, acq_sat, acq_phase, acq_peak, acq_mean, phase_err
    );
endinterface

// File: rtl/gps_ack_peak.sv
// gps_ack_peak: tracks peak, peak phase and sum over one code-phase sweep and issues a found/not-found decision
module gps_ack_peak #(
    parameter int N_PHASES  = 1023,
    parameter int PHASE_W   = 10,
    parameter int INT_W     = 12,
    parameter int THRESH_Q4 = 40
) (
    input  logic           clk,
    input  logic           rst,
    gps_ack_peak_if.slave  bus
);
    localparam int SUM_W = INT_W + 10;
    localparam int CNT_W = $clog2(N_PHASES + 1);
    localparam int CMP_W = INT_W + 8;

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

    state_t             state, state_nx;
    logic               cc_q;
    logic [4:0]         sat_q;
    logic [INT_W-1:0]   peak;
    logic [PHASE_W-1:0] peak_phase;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   count;
    logic               perr;
    logic               valid_q;
    logic               found_q;
    logic [4:0]         asat_q;
    logic [PHASE_W-1:0] aphase_q;
    logic [INT_W-1:0]   apeak_q;
    logic [INT_W-1:0]   amean_q;
    logic               accept;
    logic               in_range;
    logic               last;
    logic [INT_W-1:0]   mean;
    logic [CMP_W-1:0]   lhs;
    logic [CMP_W-1:0]   rhs;

    // a restart on the same cycle as a result edge discards that result
    assign accept   = state == ACCUM && bus.corr_complete && !cc_q && !bus.sweep_start;
    assign in_range = {1'b0, bus.code_phase} < (PHASE_W + 1)'(N_PHASES);
    assign last     = accept && in_range && count == CNT_W'(N_PHASES - 1);
    assign mean     = sum[SUM_W-1 -: INT_W];
    assign lhs      = CMP_W'({peak, 4'b0});
    assign rhs      = CMP_W'(mean) * CMP_W'(THRESH_Q4);

    assign bus.busy         = state != IDLE;
    assign bus.result_valid = valid_q;
    assign bus.acq_found    = found_q;
    assign bus.acq_sat      = asat_q;
    assign bus.acq_phase    = aphase_q;
    assign bus.acq_peak     = apeak_q;
    assign bus.acq_mean     = amean_q;
    assign bus.phase_err    = perr;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // sweep_start restarts from any state; DECIDE lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.sweep_start ? ACCUM : IDLE;
            ACCUM:   state_nx = bus.sweep_start ? ACCUM : last ? DECIDE : ACCUM;
            DECIDE:  state_nx = bus.sweep_start ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // edge detect, sweep accumulation and decision registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cc_q       <= 1'b0;
            sat_q      <= '0;
            peak       <= '0;
            peak_phase <= '0;
            sum        <= '0;
            count      <= '0;
            perr       <= 1'b0;
            valid_q    <= 1'b0;
            found_q    <= 1'b0;
            asat_q     <= '0;
            aphase_q   <= '0;
            apeak_q    <= '0;
            amean_q    <= '0;
        end else begin
            cc_q    <= bus.corr_complete;
            valid_q <= state == DECIDE;
            if (state == DECIDE) begin
                found_q  <= lhs >= rhs;
                asat_q   <= sat_q;
                aphase_q <= peak_phase;
                apeak_q  <= peak;
                amean_q  <= mean;
            end
            if (bus.sweep_start) begin
                sat_q      <= bus.sat_in;
                peak       <= '0;
                peak_phase <= '0;
                sum        <= '0;
                count      <= '0;
                perr       <= 1'b0;
            end else if (accept) begin
                if (!in_range) begin
                    perr <= 1'b1;
                end else begin
                    sum   <= sum + SUM_W'(bus.integrator);
                    count <= count + CNT_W'(1);
                    if (bus.integrator > peak) begin
                        peak       <= bus.integrator;
                        peak_phase <= bus.code_phase;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gps_ack_peak.sv
// tb_gps_ack_peak: random and directed sweeps checked every cycle against a sweep-level reference model
module tb_gps_ack_peak;
    localparam int N      = 1023;
    localparam int THRESH = 40;

    typedef struct packed {
        int act;
        int dec;
        int cnt;
        int sum;
        int peak;
        int pph;
        int perr;
        int sat;
        int prev;
        int valid;
        int found;
        int osat;
        int ophase;
        int opeak;
        int omean;
    } model_t;

    logic   clk;
    logic   rst;
    int     checks;
    int     errors;
    int     cyc;
    int     last_rise;
    int     n_valid;
    int     vals [N];
    model_t m;

    gps_ack_peak_if bus ();

    gps_ack_peak dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // next model state from the sweep rules: sum/peak over in-range results, decision one cycle after the last
    function automatic model_t nxt(model_t c, int ss, int sat, int cc, int ph, int iv);
        model_t n = c;
        n.valid = 0;
        if (c.dec != 0) begin
            n.dec    = 0;
            n.valid  = 1;
            n.omean  = c.sum / 1024;
            n.opeak  = c.peak;
            n.ophase = c.pph;
            n.osat   = c.sat;
            n.found  = (c.peak * 16 >= n.omean * THRESH) ? 1 : 0;
        end
        if (ss != 0) begin
            n.act  = 1;
            n.cnt  = 0;
            n.sum  = 0;
            n.peak = 0;
            n.pph  = 0;
            n.perr = 0;
            n.sat  = sat;
        end else if (c.act != 0 && cc != 0 && c.prev == 0) begin
            if (ph >= N) n.perr = 1;
            else begin
                n.sum = c.sum + iv;
                n.cnt = c.cnt + 1;
                if (iv > c.peak) begin
                    n.peak = iv;
                    n.pph  = ph;
                end
                if (n.cnt == N) begin
                    n.act = 0;
                    n.dec = 1;
                end
            end
        end
        n.prev = cc;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= nxt(m, int'(bus.sweep_start), int'(bus.sat_in), int'(bus.corr_complete),
                           int'(bus.code_phase), int'(bus.integrator));
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, plus decision latency
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", int'(bus.busy), (m.act != 0 || m.dec != 0) ? 1 : 0);
            chk("result_valid", int'(bus.result_valid), m.valid);
            chk("acq_found", int'(bus.acq_found), m.found);
            chk("acq_sat", int'(bus.acq_sat), m.osat);
            chk("acq_phase", int'(bus.acq_phase), m.ophase);
            chk("acq_peak", int'(bus.acq_peak), m.opeak);
            chk("acq_mean", int'(bus.acq_mean), m.omean);
            chk("phase_err", int'(bus.phase_err), m.perr);
            if (rst && bus.result_valid) begin
                n_valid++;
                chk("latency", cyc - last_rise, 2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sat);
        bus.sweep_start = 1'b1;
        bus.sat_in      = 5'(sat);
        step();
        bus.sweep_start = 1'b0;
    endtask

    task automatic send(input int ph, input int iv, input int hi, input int lo);
        bus.corr_complete = 1'b1;
        bus.code_phase    = 10'(ph);
        bus.integrator    = 12'(iv);
        last_rise         = cyc;
        repeat (hi) step();
        bus.corr_complete = 1'b0;
        repeat (lo) step();
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) vals[i] = v;
    endtask

    task automatic fill_rand(input int hi);
        for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, hi));
    endtask

    // one sweep over vals; optional out-of-range insert and restart during the decision cycle
    task automatic run_sweep(input int sat, input bit do_start, input int hi, input bit rnd,
                             input int oor_at, input int dr_sat);
        if (do_start) start(sat);
        for (int i = 0; i < N; i++) begin
            if (i == oor_at) send(1023, int'($urandom_range(0, 4095)), 1, 1);
            if (i == N - 1 && dr_sat >= 0) begin
                bus.corr_complete = 1'b1;
                bus.code_phase    = 10'(i);
                bus.integrator    = 12'(vals[i]);
                last_rise         = cyc;
                step();
                bus.corr_complete = 1'b0;
                bus.sweep_start   = 1'b1;
                bus.sat_in        = 5'(dr_sat);
                step();
                bus.sweep_start   = 1'b0;
            end else begin
                send(i, vals[i], rnd ? int'($urandom_range(1, 3)) : hi, rnd ? int'($urandom_range(1, 2)) : 1);
            end
        end
    endtask

    task automatic wait_rv(input int n0);
        for (int i = 0; i < 8 && n_valid == n0; i++) step();
        chk("valid_count", n_valid, n0 + 1);
    endtask

    task automatic expect_dec(input int f, input int s, input int ph, input int pk, input int mn);
        chk("lit_found", int'(bus.acq_found), f);
        chk("lit_sat", int'(bus.acq_sat), s);
        chk("lit_phase", int'(bus.acq_phase), ph);
        chk("lit_peak", int'(bus.acq_peak), pk);
        chk("lit_mean", int'(bus.acq_mean), mn);
    endtask

    initial begin
        int n0;
        checks = 0; errors = 0; cyc = 0; last_rise = 0; n_valid = 0;
        rst = 1'b0;
        bus.sweep_start = 1'b0; bus.sat_in = '0; bus.corr_complete = 1'b0;
        bus.code_phase = '0; bus.integrator = '0;
        repeat (3) step();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_valid", int'(bus.result_valid), 0);
        rst = 1'b1;
        step();

        fill(100);
        n0 = n_valid; run_sweep(4, 1, 1, 0, -1, -1); wait_rv(n0);
        expect_dec(0, 4, 0, 100, 99);

        fill(100); vals[512] = 600;
        n0 = n_valid; run_sweep(2, 1, 1, 0, -1, -1); wait_rv(n0);
        expect_dec(1, 2, 512, 600, 100);

        fill(50); vals[77] = 900;
        n0 = n_valid; run_sweep(6, 1, 3, 0, -1, -1); wait_rv(n0);
        expect_dec(1, 6, 77, 900, 50);

        fill(100);
        n0 = n_valid; run_sweep(9, 1, 1, 0, 500, -1); wait_rv(n0);
        expect_dec(0, 9, 0, 100, 99);
        chk("lit_phase_err", int'(bus.phase_err), 1);

        fill(100); vals[10] = 300; vals[700] = 300;
        n0 = n_valid; run_sweep(11, 1, 1, 0, -1, -1); wait_rv(n0);
        expect_dec(1, 11, 10, 300, 100);

        n0 = n_valid;
        start(9);
        for (int i = 0; i < 200; i++) send(i, 100, 1, 1);
        chk("abort_no_valid", n_valid, n0);
        fill(100); vals[3] = 250;
        run_sweep(7, 1, 1, 0, -1, -1); wait_rv(n0);
        expect_dec(1, 7, 3, 250, 100);

        fill(0);
        n0 = n_valid; run_sweep(1, 1, 1, 0, -1, -1); wait_rv(n0);
        expect_dec(1, 1, 0, 0, 0);

        fill_rand(4095);
        n0 = n_valid; run_sweep(int'($urandom_range(0, 31)), 1, 1, 1, int'($urandom_range(0, 1022)), -1); wait_rv(n0);
        fill_rand(200); vals[$urandom_range(0, 1022)] = int'($urandom_range(1500, 4095));
        n0 = n_valid; run_sweep(int'($urandom_range(0, 31)), 1, 1, 1, -1, -1); wait_rv(n0);

        start(3);
        for (int i = 0; i < 5; i++) send(i, 4000, 1, 1);
        bus.corr_complete = 1'b1; bus.code_phase = 10'd5; bus.integrator = 12'd4095;
        bus.sweep_start = 1'b1; bus.sat_in = 5'd3;
        step();
        bus.sweep_start = 1'b0; bus.corr_complete = 1'b0;
        step();
        fill_rand(200);
        n0 = n_valid; run_sweep(3, 0, 1, 1, -1, 12); wait_rv(n0);
        chk("coincident_peak_max", (int'(bus.acq_peak) <= 200) ? 1 : 0, 1);
        fill_rand(300); vals[900] = 4000;
        n0 = n_valid; run_sweep(12, 0, 1, 0, -1, -1); wait_rv(n0);
        chk("restart_sat", int'(bus.acq_sat), 12);
        chk("restart_phase", int'(bus.acq_phase), 900);

        start(5);
        for (int i = 0; i < 100; i++) send(i, 100, 1, 1);
        n0 = n_valid;
        #2 rst = 1'b0;
        #1;
        chk("async_busy", int'(bus.busy), 0);
        chk("async_peak", int'(bus.acq_peak), 0);
        chk("async_sat", int'(bus.acq_sat), 0);
        chk("async_phase", int'(bus.acq_phase), 0);
        chk("async_found", int'(bus.acq_found), 0);
        step(); step();
        rst = 1'b1;
        repeat (3) step();
        chk("async_no_valid", n_valid, n0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
